// File: rtl/mem_rd_arbiter.sv
// Shares the main-memory read port between icache and dcache, locking the grant for a whole line burst.
// Optional feature: define ARB_ROUND_ROBIN_EN for round-robin tie breaking (default: dcache wins ties).
module mem_rd_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int LINE_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  ic_rd_en,
  input  logic [ADDR_WIDTH-1:0] ic_rd_addr,
  output logic [DATA_WIDTH-1:0] ic_rd_data,
  output logic                  ic_rd_valid,
  input  logic                  dc_rd_en,
  input  logic [ADDR_WIDTH-1:0] dc_rd_addr,
  output logic [DATA_WIDTH-1:0] dc_rd_data,
  output logic                  dc_rd_valid,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  input  logic                  mem_rd_valid,
  output logic                  ic_gnt,
  output logic                  dc_gnt,
  output logic                  drop_err
);

  localparam int CNT_W = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, GNT_IC, GNT_DC} state_t;
  typedef enum logic {OWN_IC, OWN_DC} owner_t;

  state_t           state, state_nxt;
  owner_t           last, last_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             tie_to_ic;

`ifdef ARB_ROUND_ROBIN_EN
  assign tie_to_ic = (last == OWN_DC);
`else
  assign tie_to_ic = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      cnt      <= '0;
      last     <= OWN_DC;
      drop_err <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      last  <= last_nxt;
      if (state == IDLE && mem_rd_valid)
        drop_err <= 1'b1;
    end
  end

  // A burst ends on its final beat or when the owner withdraws its enable.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    last_nxt  = last;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (ic_rd_en && dc_rd_en)
          state_nxt = tie_to_ic ? GNT_IC : GNT_DC;
        else if (ic_rd_en)
          state_nxt = GNT_IC;
        else if (dc_rd_en)
          state_nxt = GNT_DC;
      end
      GNT_IC: begin
        if (mem_rd_valid)
          cnt_nxt = cnt + 1'b1;
        if ((mem_rd_valid && cnt == LAST_BEAT) || !ic_rd_en) begin
          state_nxt = IDLE;
          last_nxt  = OWN_IC;
        end
      end
      GNT_DC: begin
        if (mem_rd_valid)
          cnt_nxt = cnt + 1'b1;
        if ((mem_rd_valid && cnt == LAST_BEAT) || !dc_rd_en) begin
          state_nxt = IDLE;
          last_nxt  = OWN_DC;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_rd_en   = 1'b0;
    mem_rd_addr = '0;
    ic_rd_valid = 1'b0;
    dc_rd_valid = 1'b0;
    case (state)
      GNT_IC: begin
        mem_rd_en   = ic_rd_en;
        mem_rd_addr = ic_rd_addr;
        ic_rd_valid = mem_rd_valid;
      end
      GNT_DC: begin
        mem_rd_en   = dc_rd_en;
        mem_rd_addr = dc_rd_addr;
        dc_rd_valid = mem_rd_valid;
      end
      default: ;
    endcase
  end

  assign ic_rd_data = mem_rd_data;
  assign dc_rd_data = mem_rd_data;
  assign ic_gnt     = (state == GNT_IC);
  assign dc_gnt     = (state == GNT_DC);

endmodule
